fixed_adder_tree_arbiter: RTL
=============================

FIXED_ADDER_TREE_ARBITER -- requirements
Module: fixed_adder_tree_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one adder tree.
REQ-002 SHALL have parameter IN_SIZE, default 4: elements per request vector.
REQ-003 SHALL have parameter IN_WIDTH, default 32: element width.
REQ-004 SHALL have parameter OUT_WIDTH, default $clog2(IN_SIZE)+IN_WIDTH: tree result width.
REQ-005 SHALL have parameter TAG_DEPTH, default 8: maximum in-flight sums; must be ≥ tree latency (tree depth + 1).
REQ-006 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have ports req_data, input, [IN_WIDTH-1:0] x [NUM_REQ][IN_SIZE]; req_valid, input, NUM_REQ; req_ready, output, NUM_REQ: per-requester operand streams.
REQ-009 SHALL have ports tree_data_in, output, [IN_WIDTH-1:0] x [IN_SIZE]; tree_data_in_valid, output, 1; tree_data_in_ready, input, 1: drive the shared tree input.
REQ-010 SHALL have ports tree_data_out, input, OUT_WIDTH; tree_data_out_valid, input, 1; tree_data_out_ready, output, 1: the shared tree output.
REQ-011 SHALL have ports resp_data, output, OUT_WIDTH (broadcast); resp_valid, output, NUM_REQ; resp_ready, input, NUM_REQ: per-requester results.

Function
REQ-012 SHALL use valid/ready handshakes on all streams; a transfer occurs when valid and ready are both high on a rising edge.
REQ-013 SHALL issue when any req_valid is high and the tag FIFO is not full; tree_data_in_valid = issue condition, with no added latency (combinational path from req_valid).
REQ-014 SHALL grant round-robin: search starts at the priority pointer; after a tree input transfer the pointer becomes winner+1, wrapping from NUM_REQ-1 to 0.
REQ-015 SHALL lock the grant while tree_data_in_valid is high and tree_data_in_ready is low; the winner and tree_data_in stay stable until transfer, even if a higher-priority request arrives.
REQ-016 SHALL drive req_ready[g] = tree_data_in_ready for the granted index g only; all other req_ready bits low.
REQ-017 SHALL push the winner index (TAG_WIDTH = $clog2(NUM_REQ) bits, min 1) into the tag FIFO on each tree input transfer.
REQ-018 SHALL not push when the FIFO holds TAG_DEPTH entries, even if a pop occurs in the same cycle; the tree input is blocked instead.
REQ-019 SHALL route results in order: with head tag t and FIFO non-empty, resp_valid[t] = tree_data_out_valid, all other resp_valid bits low, tree_data_out_ready = resp_ready[t].
REQ-020 SHALL pop the head tag on each tree output transfer; a simultaneous push and pop leaves occupancy unchanged.
REQ-021 SHALL hold tree_data_out_ready low and all resp_valid low when the FIFO is empty; tree_data_out_valid with an empty FIFO is a protocol error, flagged by assertion.
REQ-022 SHALL pass data unmodified (no width change or sign handling); resp_data = tree_data_out.
REQ-023 SHALL let a stalled resp_ready on one requester stall the whole tree output (in-order, head-of-line blocking by design).

Reset
REQ-024 SHALL, on rst, clear the FIFO (empty), set the priority pointer to 0 and release the lock.
REQ-025 SHALL hold req_ready, resp_valid, tree_data_in_valid and tree_data_out_ready at 0 while rst is high.
REQ-026 SHALL discard in-flight tags on reset mid-operation; the tree is reset on the same rst, so no orphan result returns.

Structure
REQ-027 SHALL place no typedefs in a shared package; TAG_WIDTH is a local constant.
REQ-028 SHALL implement the tag store as one sub-module, tag_fifo (TAG_DEPTH x TAG_WIDTH, registered, count-based full/empty).

Verification
REQ-029 Single requester: req 2 sends {1,2,3,4}, tree latency 3 -> resp_valid[2] with resp_data 10; other resp_valid stay 0.
REQ-030 All four requesters valid continuously with tree always ready -> grants 0,1,2,3,0 on consecutive cycles; results return in the same order.
REQ-031 Backpressure lock: req 1 granted, tree_data_in_ready low 5 cycles while req 0 asserts -> grant stays 1; req 0 wins only after pointer passes it.
REQ-032 FIFO full: TAG_DEPTH=2, tree output stalled -> third issue blocked (tree_data_in_valid=0) until one pop, with no push in the pop cycle.
REQ-033 Output stall: resp_ready[3]=0 at head -> tree_data_out_ready=0; later results for req 0 wait; no loss or reordering.
REQ-034 Reset with 3 in flight -> all outputs 0 next cycle, pointer 0; a new request to req 3 completes correctly.

Source files
------------

// File: rtl/fixed_adder_tree_arbiter_pkg.sv
// Shared helpers for the adder-tree arbiter slice.
// Only functions live here; each module keeps its own local widths.
package fixed_adder_tree_arbiter_pkg;

    // Index width that never collapses to zero bits for a single entry.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fixed_adder_tree_arbiter_tag_fifo.sv
// In-order tag store: records which requester owns each in-flight tree sum.
// Pushes are dropped while full, even when a pop lands in the same cycle.
module tag_fifo
    import fixed_adder_tree_arbiter_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = clog2_min1(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q];

    always_comb begin
        wr_d  = do_push ? nxt(wr_q) : wr_q;
        rd_d  = do_pop  ? nxt(rd_q) : rd_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/fixed_adder_tree_arbiter.sv
// Round-robin front end sharing one adder tree among NUM_REQ requesters;
// results are routed back in issue order using a tag FIFO.
module fixed_adder_tree_arbiter
    import fixed_adder_tree_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int IN_SIZE   = 4,
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = $clog2(IN_SIZE) + IN_WIDTH,
    parameter int TAG_DEPTH = 8
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_REQ-1:0][IN_SIZE-1:0][IN_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]                          req_valid,
    output logic [NUM_REQ-1:0]                          req_ready,
    output logic [IN_SIZE-1:0][IN_WIDTH-1:0]            tree_data_in,
    output logic                                        tree_data_in_valid,
    input  logic                                        tree_data_in_ready,
    input  logic [OUT_WIDTH-1:0]                        tree_data_out,
    input  logic                                        tree_data_out_valid,
    output logic                                        tree_data_out_ready,
    output logic [OUT_WIDTH-1:0]                        resp_data,
    output logic [NUM_REQ-1:0]                          resp_valid,
    input  logic [NUM_REQ-1:0]                          resp_ready
);
    localparam int TAG_WIDTH = clog2_min1(NUM_REQ);

    logic [TAG_WIDTH-1:0] ptr_q, ptr_d, lock_idx_q, lock_idx_d;
    logic                 lock_q, lock_d;
    logic [TAG_WIDTH-1:0] rr_win, grant, head_tag;
    logic                 any_vld, fifo_full, fifo_empty, in_fire, out_fire;

    // First valid requester at or after the priority pointer.
    always_comb begin
        int j;
        rr_win  = '0;
        any_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr_q) + i) % NUM_REQ;
            if (!any_vld && req_valid[j]) begin
                any_vld = 1'b1;
                rr_win  = TAG_WIDTH'(j);
            end
        end
    end

    // A stalled offer keeps its winner so tree_data_in cannot change mid-handshake.
    assign grant              = lock_q ? lock_idx_q : rr_win;
    assign tree_data_in_valid = !rst && !fifo_full && (lock_q ? req_valid[lock_idx_q] : any_vld);
    assign tree_data_in       = req_data[grant];
    assign in_fire            = tree_data_in_valid && tree_data_in_ready;

    always_comb begin
        req_ready        = '0;
        req_ready[grant] = in_fire;
    end

    always_comb begin
        lock_d     = tree_data_in_valid && !tree_data_in_ready;
        lock_idx_d = grant;
        ptr_d      = ptr_q;
        if (in_fire)
            ptr_d = (grant == TAG_WIDTH'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // Head tag owns the tree output; any other requester waits behind it.
    always_comb begin
        resp_valid          = '0;
        tree_data_out_ready = 1'b0;
        if (!rst && !fifo_empty) begin
            resp_valid[head_tag] = tree_data_out_valid;
            tree_data_out_ready  = resp_ready[head_tag];
        end
    end

    assign resp_data = tree_data_out;
    assign out_fire  = tree_data_out_valid && tree_data_out_ready;

    tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (TAG_WIDTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_fire),
        .din_i   (grant),
        .pop_i   (out_fire),
        .head_o  (head_tag),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    a_no_orphan_result: assert property (@(posedge clk) disable iff (rst)
        !(tree_data_out_valid && fifo_empty));

endmodule
